load_align_ext: RTL and testbench
=================================

Name: load_align_ext

Overview:
- Parametrised successor to the load-data extender.
- Accepts one load request at a time: byte address plus extend op.
- Issues one or two aligned reads on the data-memory port, then lane-aligns, merges and sign/zero-extends the read data.
- Returns the result to the MEM/WB stage over a valid/ready handshake.
- Flags misaligned and illegal-op loads so the exception unit can trap them.

Parameters:
- XLEN, 32, datapath width and bus word width in bits; legal values 32 or 64.
- BYTES, XLEN/8, bytes per bus word; derived, not overridable.
- OFFW, log2(BYTES), width of the byte-offset field; derived.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; abandons the current load.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  XLEN  byte address.
- req_op  in  3  extend op: 0=B, 1=BU, 2=H, 3=HU, 4=W, 5=WU, 6=D, 7=reserved.
- bus_rd_en  out  1  read strobe, held until bus_ack.
- bus_addr  out  XLEN  word-aligned read address; low OFFW bits are always 0.
- bus_rdata  in  XLEN  read data, valid in the cycle bus_ack=1.
- bus_ack  in  1  read complete.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  XLEN  extended load data.
- resp_misaligned  out  1  load-address-misaligned exception flag.
- resp_illegal  out  1  illegal op for this XLEN.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - req_ready=1; bus_rd_en=0; bus_addr=0.
  - resp_valid=0; resp_data=0; resp_misaligned=0; resp_illegal=0.
- Access size:
  - B/BU=1 byte, H/HU=2, W/WU=4, D=8.
  - WU and D are illegal when XLEN=32; op 7 is always illegal.
- Offset and boundary:
  - off = addr[OFFW-1:0].
  - misaligned = (off mod size) != 0.
  - crossing = off + size > BYTES.
- States: IDLE, RD0, RD1, RESP, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr and op.
  - Illegal op: go to RESP with resp_illegal=1, resp_data=0, no bus access.
  - Misaligned (feature off): go to RESP with resp_misaligned=1, resp_data=0, no bus access.
  - Otherwise go to RD0.
  - req_ready=0 in every other state.
- RD0:
  - bus_rd_en=1, bus_addr = addr with low OFFW bits cleared.
  - On bus_ack, capture bus_rdata into lo.
  - Then go to RD1 if crossing, else RESP.
  - Earliest bus strobe is the cycle after acceptance.
- RD1:
  - bus_addr = RD0 address + BYTES, wrapping modulo 2^XLEN.
  - On bus_ack, capture into hi, then go to RESP.
- Result formation (registered on entry to RESP):
  - raw = ({hi,lo} >> (off*8)) truncated to size bytes; hi=0 for single-beat accesses.
  - B/H/W/D sign-extend from the top bit of the field.
  - BU/HU/WU zero-extend.
- RESP:
  - resp_valid=1; resp_* held stable until resp_ready=1.
  - Then go to IDLE; all resp_* return to 0 next cycle.
- Latency with zero-wait bus (ack in same cycle as strobe) and resp_ready=1:
  - Aligned load: resp_valid 2 cycles after acceptance.
  - Crossing load: 3 cycles after acceptance.
  - Misaligned/illegal load: 1 cycle after acceptance.
- flush (highest priority, takes effect next cycle):
  - IDLE or RESP: go to IDLE, resp_valid drops, response discarded.
  - RD0/RD1 with bus_ack=0 that cycle: go to DRAIN. DRAIN keeps bus_rd_en=1 until bus_ack, discards the data, then goes to IDLE.
  - RD0/RD1 with bus_ack=1 that cycle: go to IDLE directly.
  - A request presented in the same cycle as flush is not accepted.
- bus_ack outside RD0/RD1/DRAIN is ignored.

Optional Feature:
- Macro: LOAD_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned, non-crossing loads complete in one read via the shift.
  - Crossing loads use RD0+RD1.
  - resp_misaligned is never set.
- Undefined:
  - Any misaligned load returns resp_misaligned=1 with no bus traffic.
  - RD1 is unreachable.
- Aligned-load timing is identical in both builds.

Test Plan:
- XLEN=32, addr=0x1003, op=B, bus_rdata=0x80FF_1234 -> single read at bus_addr=0x1000; resp_data=0xFFFF_FF80; resp_misaligned=0.
- XLEN=32, addr=0x2002, op=HU, rdata=0xBEEF_0000 -> resp_data=0x0000_BEEF. addr=0x2001, op=H, rdata=0x00AB_CD00 -> split build: 0xFFFF_ABCD; non-split build: resp_misaligned=1, no bus_rd_en.
- Split build, XLEN=32, addr=0x3006, op=W, reads 0x3004 -> 0x5566_0000 and 0x3008 -> 0x0000_7788 -> resp_data=0x7788_5566, 3-cycle latency with zero-wait bus.
- XLEN=32, op=D -> resp_illegal=1, resp_data=0, no bus access. XLEN=64, addr=0x8, op=WU, rdata=0x0000_0000_8000_0001 -> resp_data=0x0000_0000_8000_0001.
- flush in RD0 while bus_ack is delayed 3 cycles -> bus_rd_en held until ack, no resp_valid, req_ready=1 the cycle after ack.
- resp_ready held 0 for 4 cycles -> resp_valid and resp_data stable. rst asserted mid-RD1 -> all outputs at reset values immediately; next request behaves normally.

Source files
------------

// File: rtl/load_align_ext.sv
// load_align_ext: one-at-a-time load unit that reads one or two aligned bus words, then lane-aligns and extends the data.
// Optional build macro LOAD_MISALIGN_SPLIT_EN enables in-hardware handling of misaligned loads. Rev 1.0.
`default_nettype none

module load_align_ext #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_op,
  output logic            bus_rd_en,
  output logic [XLEN-1:0] bus_addr,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_misaligned,
  output logic            resp_illegal
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD0, RD1, RESP, DRAIN} state_t;
  state_t state, state_n;

  logic [OFFW-1:0] off_q, off_s;
  logic [2:0]      op_q, op_s;
  logic [XLEN-1:0] lo_q, addr_q;
  logic [XLEN-1:0] data_q;
  logic            mis_q, ill_q;

  logic [3:0]        size_b, off4;
  logic              misaligned, crossing, illegal;
  logic [2*XLEN-1:0] beat_pair;
  logic [XLEN-1:0]   field, keep, ext;
  logic              sign_bit;

  logic            load_resp, clr_resp;
  logic [XLEN-1:0] nxt_data;
  logic            nxt_mis, nxt_ill;

  // Decode from the live request while idle, from the latched copy afterwards.
  assign off_s = (state == IDLE) ? req_addr[OFFW-1:0] : off_q;
  assign op_s  = (state == IDLE) ? req_op : op_q;

  always_comb begin
    size_b     = 4'd1 << op_s[2:1];
    off4       = 4'(off_s);
    misaligned = |(off4 & (size_b - 4'd1));
    crossing   = ({1'b0, off4} + {1'b0, size_b}) > 5'(BYTES);
    illegal    = (op_s == 3'd7) || ((XLEN == 32) && ((op_s == 3'd5) || (op_s == 3'd6)));
  end

  // Second beat supplies the upper half of the pair; single-beat loads see zeros there.
  always_comb begin
    beat_pair = (state == RD1) ? {bus_rdata, lo_q} : {{XLEN{1'b0}}, bus_rdata};
    field     = XLEN'(beat_pair >> {off_s, 3'b000});
    case (op_s[2:1])
      2'd0:    begin keep = XLEN'(8'hFF);         sign_bit = field[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sign_bit = field[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sign_bit = field[31];     end
      default: begin keep = '1;                   sign_bit = field[XLEN-1]; end
    endcase
    ext = (field & keep) | ({XLEN{sign_bit & ~op_s[0]}} & ~keep);
  end

  always_comb begin
    state_n   = state;
    load_resp = 1'b0;
    clr_resp  = 1'b0;
    nxt_data  = '0;
    nxt_mis   = 1'b0;
    nxt_ill   = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && req_valid) begin
          if (illegal) begin
            state_n   = RESP;
            load_resp = 1'b1;
            nxt_ill   = 1'b1;
          end else if (misaligned && !SPLIT) begin
            state_n   = RESP;
            load_resp = 1'b1;
            nxt_mis   = 1'b1;
          end else begin
            state_n = RD0;
          end
        end
      end
      RD0: begin
        if (flush) begin
          state_n = bus_ack ? IDLE : DRAIN;
        end else if (bus_ack) begin
          if (crossing) begin
            state_n = RD1;
          end else begin
            state_n   = RESP;
            load_resp = 1'b1;
            nxt_data  = ext;
          end
        end
      end
      RD1: begin
        if (flush) begin
          state_n = bus_ack ? IDLE : DRAIN;
        end else if (bus_ack) begin
          state_n   = RESP;
          load_resp = 1'b1;
          nxt_data  = ext;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          state_n  = IDLE;
          clr_resp = 1'b1;
        end
      end
      DRAIN: begin
        if (bus_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      op_q   <= '0;
      lo_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      mis_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid && !flush) begin
        off_q  <= req_addr[OFFW-1:0];
        op_q   <= req_op;
        addr_q <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      end
      if (state == RD0 && bus_ack && !flush) begin
        lo_q <= bus_rdata;
        if (crossing) addr_q <= addr_q + XLEN'(BYTES);
      end
      if (load_resp) begin
        data_q <= nxt_data;
        mis_q  <= nxt_mis;
        ill_q  <= nxt_ill;
      end else if (clr_resp) begin
        data_q <= '0;
        mis_q  <= 1'b0;
        ill_q  <= 1'b0;
      end
    end
  end

  assign req_ready       = (state == IDLE);
  assign bus_rd_en       = (state == RD0) || (state == RD1) || (state == DRAIN);
  assign bus_addr        = addr_q;
  assign resp_valid      = (state == RESP);
  assign resp_data       = data_q;
  assign resp_misaligned = mis_q;
  assign resp_illegal    = ill_q;

endmodule

`default_nettype wire

// File: tb/tb_load_align_ext.sv
// tb_load_align_ext: directed self-checking bench for load_align_ext (XLEN=32 and XLEN=64 instances).
`default_nettype none

module tb_load_align_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic        bus_rd_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_misaligned;
  logic        resp_illegal;

  logic        flush64 = 1'b0;
  logic        req_valid64 = 1'b0;
  logic        req_ready64;
  logic [63:0] req_addr64 = '0;
  logic [2:0]  req_op64 = '0;
  logic        bus_rd_en64;
  logic [63:0] bus_addr64;
  logic [63:0] bus_rdata64 = '0;
  logic        bus_ack64;
  logic        resp_valid64;
  logic        resp_ready64 = 1'b1;
  logic [63:0] resp_data64;
  logic        resp_misaligned64;
  logic        resp_illegal64;

  int checks = 0;
  int errors = 0;

  logic [31:0] word0_addr = '0;
  logic [31:0] word0_data = '0;
  logic [31:0] word1_data = '0;
  int          ack_delay = 0;
  int          wcnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] prev_addr = '0;

  assign bus_ack   = bus_rd_en && (wcnt >= ack_delay);
  assign bus_rdata = (bus_addr == word0_addr) ? word0_data : word1_data;
  assign bus_ack64 = bus_rd_en64;

  always @(posedge clk) begin
    if (!bus_rd_en || bus_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (bus_rd_en && bus_ack) begin
      rd_cnt    <= rd_cnt + 1;
      prev_addr <= last_addr;
      last_addr <= bus_addr;
    end
  end

  load_align_ext #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_op(req_op),
    .bus_rd_en(bus_rd_en), .bus_addr(bus_addr), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal)
  );

  load_align_ext #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_addr(req_addr64), .req_op(req_op64),
    .bus_rd_en(bus_rd_en64), .bus_addr(bus_addr64), .bus_rdata(bus_rdata64), .bus_ack(bus_ack64),
    .resp_valid(resp_valid64), .resp_ready(resp_ready64), .resp_data(resp_data64),
    .resp_misaligned(resp_misaligned64), .resp_illegal(resp_illegal64)
  );

  // Issues one load with resp_ready=1, measures latency and checks the whole response.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] exp_data,
                          input logic exp_mis, input logic exp_ill, input int exp_lat, input int exp_reads,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1, input string name);
    int lat;
    int rd0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_addr = addr; req_op = op; rd0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (resp_data !== exp_data) begin
      errors++; $display("FAIL %s data got %h want %h", name, resp_data, exp_data);
    end
    checks++;
    if ({resp_misaligned, resp_illegal} !== {exp_mis, exp_ill}) begin
      errors++; $display("FAIL %s flags mis/ill got %b%b want %b%b", name, resp_misaligned, resp_illegal, exp_mis, exp_ill);
    end
    checks++;
    if (rd_cnt - rd0 != exp_reads) begin
      errors++; $display("FAIL %s reads got %0d want %0d", name, rd_cnt - rd0, exp_reads);
    end
    if (exp_reads == 1) begin
      checks++;
      if (last_addr !== exp_a0) begin
        errors++; $display("FAIL %s bus_addr got %h want %h", name, last_addr, exp_a0);
      end
    end else if (exp_reads == 2) begin
      checks++;
      if (prev_addr !== exp_a0 || last_addr !== exp_a1) begin
        errors++; $display("FAIL %s bus_addr pair got %h/%h want %h/%h", name, prev_addr, last_addr, exp_a0, exp_a1);
      end
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_data, resp_misaligned, resp_illegal} !== 35'h0) begin
      errors++; $display("FAIL %s resp_clear got v=%b d=%h m=%b i=%b want all 0", name, resp_valid, resp_data, resp_misaligned, resp_illegal);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, bus_rd_en, bus_addr, resp_valid, resp_data, resp_misaligned, resp_illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset32 got rdy=%b en=%b a=%h v=%b d=%h m=%b i=%b", req_ready, bus_rd_en, bus_addr, resp_valid, resp_data, resp_misaligned, resp_illegal);
    end
    checks++;
    if ({req_ready64, bus_rd_en64, bus_addr64, resp_valid64, resp_data64} !== {1'b1, 1'b0, 64'h0, 1'b0, 64'h0}) begin
      errors++; $display("FAIL reset64 got rdy=%b en=%b a=%h v=%b d=%h", req_ready64, bus_rd_en64, bus_addr64, resp_valid64, resp_data64);
    end
  endtask

  task automatic test_aligned;
    word0_addr = 32'h1000; word0_data = 32'h80FF_1234;
    run_load(32'h1003, 3'd0, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1, 32'h1000, 32'h0, "byte_sext");
    word0_addr = 32'h2000; word0_data = 32'hBEEF_0000;
    run_load(32'h2002, 3'd3, 32'h0000_BEEF, 1'b0, 1'b0, 2, 1, 32'h2000, 32'h0, "half_zext");
    word0_addr = 32'h4004; word0_data = 32'h8000_0001;
    run_load(32'h4004, 3'd4, 32'h8000_0001, 1'b0, 1'b0, 2, 1, 32'h4004, 32'h0, "word");
    run_load(32'h4006, 3'd2, 32'hFFFF_8000, 1'b0, 1'b0, 2, 1, 32'h4004, 32'h0, "half_sext");
    run_load(32'h4004, 3'd1, 32'h0000_0001, 1'b0, 1'b0, 2, 1, 32'h4004, 32'h0, "byte_zext");
  endtask

  task automatic test_misaligned;
    word0_addr = 32'h2000; word0_data = 32'h00AB_CD00;
`ifdef LOAD_MISALIGN_SPLIT_EN
    run_load(32'h2001, 3'd2, 32'hFFFF_ABCD, 1'b0, 1'b0, 2, 1, 32'h2000, 32'h0, "mis_half");
`else
    run_load(32'h2001, 3'd2, 32'h0, 1'b1, 1'b0, 1, 0, 32'h0, 32'h0, "mis_half");
`endif
  endtask

  task automatic test_crossing;
    word0_addr = 32'h3004; word0_data = 32'h5566_0000; word1_data = 32'h0000_7788;
`ifdef LOAD_MISALIGN_SPLIT_EN
    run_load(32'h3006, 3'd4, 32'h7788_5566, 1'b0, 1'b0, 3, 2, 32'h3004, 32'h3008, "cross_word");
    word0_addr = 32'hFFFF_FFFC; word0_data = 32'h1122_0000; word1_data = 32'h0000_3344;
    run_load(32'hFFFF_FFFE, 3'd4, 32'h3344_1122, 1'b0, 1'b0, 3, 2, 32'hFFFF_FFFC, 32'h0, "cross_wrap");
`else
    run_load(32'h3006, 3'd4, 32'h0, 1'b1, 1'b0, 1, 0, 32'h0, 32'h0, "cross_word");
`endif
  endtask

  task automatic test_illegal;
    run_load(32'h4000, 3'd6, 32'h0, 1'b0, 1'b1, 1, 0, 32'h0, 32'h0, "ill_d");
    run_load(32'h4000, 3'd5, 32'h0, 1'b0, 1'b1, 1, 0, 32'h0, 32'h0, "ill_wu");
    run_load(32'h4001, 3'd7, 32'h0, 1'b0, 1'b1, 1, 0, 32'h0, 32'h0, "ill_rsv");
  endtask

  task automatic test_flush;
    int  n;
    logic held_ok;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h5000; req_op = 3'd4; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || bus_rd_en !== 1'b0) begin
      errors++; $display("FAIL flush_req got rdy=%b en=%b want 1/0", req_ready, bus_rd_en);
    end
    ack_delay = 3;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h5000; req_op = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (bus_rd_en !== 1'b1 || bus_ack !== 1'b0) begin
      errors++; $display("FAIL flush_rd0 got en=%b ack=%b want 1/0", bus_rd_en, bus_ack);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0; held_ok = 1'b1;
    while (bus_ack !== 1'b1 && n < 10) begin
      if (bus_rd_en !== 1'b1 || resp_valid !== 1'b0) held_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!held_ok || n >= 10) begin
      errors++; $display("FAIL flush_drain got held=%b waited=%0d want 1 and <10", held_ok, n);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, bus_rd_en, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL flush_idle got rdy/en/v=%b%b%b want 100", req_ready, bus_rd_en, resp_valid);
    end
    ack_delay = 0;
  endtask

  task automatic test_backpressure;
    int n;
    word0_addr = 32'h1000; word0_data = 32'h80FF_1234;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1003; req_op = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FF80) begin
        errors++; $display("FAIL hold%0d got v=%b d=%h want 1/ffffff80", i, resp_valid, resp_data);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin
      errors++; $display("FAIL hold_release got v=%b d=%h want 0/0", resp_valid, resp_data);
    end
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1003; req_op = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({resp_valid, req_ready, resp_data} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL flush_resp got v=%b rdy=%b d=%h want 0/1/0", resp_valid, req_ready, resp_data);
    end
    resp_ready = 1'b1;
  endtask

  task automatic test_reset_mid_read;
    int n;
    ack_delay = 3;
`ifdef LOAD_MISALIGN_SPLIT_EN
    word0_addr = 32'h3004; word0_data = 32'h5566_0000; word1_data = 32'h0000_7788;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h3006; req_op = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(bus_rd_en === 1'b1 && bus_addr === 32'h3008) && n < 20) begin @(negedge clk); n++; end
`else
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; req_op = 3'd4;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (bus_rd_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
`endif
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL mid_read_reach got waited=%0d want <20", n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, bus_rd_en, bus_addr, resp_valid, resp_data, resp_misaligned, resp_illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got rdy=%b en=%b a=%h v=%b d=%h", req_ready, bus_rd_en, bus_addr, resp_valid, resp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    word0_addr = 32'h2000; word0_data = 32'hBEEF_0000;
    run_load(32'h2002, 3'd3, 32'h0000_BEEF, 1'b0, 1'b0, 2, 1, 32'h2000, 32'h0, "after_reset");
  endtask

  task automatic test_xlen64;
    logic [63:0] a [4];
    logic [2:0]  o [4];
    logic [63:0] d [4];
    logic [63:0] e [4];
    logic        il [4];
    int          n;
    a[0] = 64'h8;  o[0] = 3'd5; d[0] = 64'h0000_0000_8000_0001; e[0] = 64'h0000_0000_8000_0001; il[0] = 1'b0;
    a[1] = 64'h8;  o[1] = 3'd4; d[1] = 64'h0000_0000_8000_0001; e[1] = 64'hFFFF_FFFF_8000_0001; il[1] = 1'b0;
    a[2] = 64'h10; o[2] = 3'd6; d[2] = 64'h8123_4567_89AB_CDEF; e[2] = 64'h8123_4567_89AB_CDEF; il[2] = 1'b0;
    a[3] = 64'h10; o[3] = 3'd7; d[3] = 64'h8123_4567_89AB_CDEF; e[3] = 64'h0;                   il[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid64 = 1'b1; req_addr64 = a[i]; req_op64 = o[i]; bus_rdata64 = d[i];
      @(negedge clk);
      req_valid64 = 1'b0;
      n = 0;
      while (resp_valid64 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (resp_data64 !== e[i] || resp_illegal64 !== il[i] || n >= 20) begin
        errors++; $display("FAIL x64_%0d got d=%h i=%b want d=%h i=%b", i, resp_data64, resp_illegal64, e[i], il[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_aligned;
    test_misaligned;
    test_crossing;
    test_illegal;
    test_flush;
    test_backpressure;
    test_reset_mid_read;
    test_xlen64;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
